// File: rtl/bilat_frame_ctrl.sv
// bilat_frame_ctrl: frame sequencer feeding a bilateral filter.
// Streams one gray frame, pads it with zero pixels, then waits for the filter's outputs.
// Ports:
//   clk, rst            clock and async active-high reset
//   start, abort        frame start request / frame cancel
//   s_valid/s_ready     upstream pixel handshake, s_data pixel
//   gray_valid, gray    registered pixel strobe to the filter
//   bilat_valid         filter output strobe
//   in_row, in_col      coordinate of the last pixel sent
//   out_cnt             filter outputs counted this frame
//   busy, frame_done    activity level / completion pulse
//   timeout_err         sticky drain-timeout flag
module bilat_frame_ctrl #(
  parameter int IMAGE_WIDTH   = 320,
  parameter int IMAGE_HEIGHT  = 464,
  parameter int GAP           = 1,
  parameter int FLUSH_PIXELS  = 2*IMAGE_WIDTH+2,
  parameter int DRAIN_TIMEOUT = 300000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        gray_valid,
  output logic [7:0]  gray,
  input  logic        bilat_valid,
  output logic [31:0] in_row,
  output logic [31:0] in_col,
  output logic [31:0] out_cnt,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [31:0] TARGET   = 32'(IMAGE_WIDTH*IMAGE_HEIGHT);
  localparam logic [31:0] LAST_COL = 32'(IMAGE_WIDTH-1);
  localparam logic [31:0] LAST_ROW = 32'(IMAGE_HEIGHT-1);
  localparam logic [31:0] GAP_L    = 32'(GAP);
  localparam logic [31:0] FLUSH_N  = 32'(FLUSH_PIXELS);
  localparam logic [31:0] DR_LAST  = 32'(DRAIN_TIMEOUT-1);

  logic [2:0]  state_q, state_d;
  logic [31:0] gap_q, gap_d;
  logic [7:0]  gray_q, gray_d;
  logic        gray_valid_q, gray_valid_d;
  logic [31:0] in_row_q, in_row_d;
  logic [31:0] in_col_q, in_col_d;
  logic [31:0] pos_row_q, pos_row_d;
  logic [31:0] pos_col_q, pos_col_d;
  logic [31:0] out_cnt_q, out_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] drain_cnt_q, drain_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  logic accept;
  logic last_pix;
  logic cnt_en;

  assign s_ready     = (state_q == S_STREAM) && (gap_q == '0);
  assign gray_valid  = gray_valid_q;
  assign gray        = gray_q;
  assign in_row      = in_row_q;
  assign in_col      = in_col_q;
  assign out_cnt     = out_cnt_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = (state_q == S_DONE);
  assign timeout_err = timeout_err_q;

  assign accept   = s_valid && s_ready;
  assign last_pix = (pos_row_q == LAST_ROW) && (pos_col_q == LAST_COL);
  assign cnt_en   = bilat_valid &&
                    ((state_q == S_STREAM) ||
                     (state_q == S_FLUSH) ||
                     (state_q == S_DRAIN));

  always_comb begin
    state_d       = state_q;
    gap_d         = (gap_q != '0) ? gap_q - 32'd1 : '0;
    gray_d        = gray_q;
    gray_valid_d  = 1'b0;
    in_row_d      = in_row_q;
    in_col_d      = in_col_q;
    pos_row_d     = pos_row_q;
    pos_col_d     = pos_col_q;
    out_cnt_d     = out_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    timeout_err_d = timeout_err_q;

    // abort freezes every counter and only drops back to IDLE
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      gap_d   = '0;
    end else begin
      if (cnt_en && (out_cnt_q < TARGET)) begin
        out_cnt_d = out_cnt_q + 32'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d       = S_STREAM;
            gap_d         = '0;
            in_row_d      = '0;
            in_col_d      = '0;
            pos_row_d     = '0;
            pos_col_d     = '0;
            out_cnt_d     = '0;
            flush_cnt_d   = '0;
            drain_cnt_d   = '0;
            timeout_err_d = 1'b0;
          end
        end
        S_STREAM: begin
          if (accept) begin
            gray_d       = s_data;
            gray_valid_d = 1'b1;
            gap_d        = GAP_L;
            in_row_d     = pos_row_q;
            in_col_d     = pos_col_q;
            if (last_pix) begin
              state_d = (FLUSH_N == '0) ? S_DRAIN : S_FLUSH;
            end else if (pos_col_q == LAST_COL) begin
              pos_col_d = '0;
              pos_row_d = pos_row_q + 32'd1;
            end else begin
              pos_col_d = pos_col_q + 32'd1;
            end
          end
        end
        S_FLUSH: begin
          if (gap_q == '0) begin
            gray_d       = 8'h00;
            gray_valid_d = 1'b1;
            gap_d        = GAP_L;
            flush_cnt_d  = flush_cnt_q + 32'd1;
            // leave on the edge that issues the final padding pulse
            if (flush_cnt_q == FLUSH_N - 32'd1) begin
              state_d     = S_DRAIN;
              drain_cnt_d = '0;
            end
          end
        end
        S_DRAIN: begin
          drain_cnt_d = drain_cnt_q + 32'd1;
          // a complete count wins over a simultaneous timeout
          if (out_cnt_q >= TARGET) begin
            state_d = S_DONE;
          end else if (drain_cnt_q == DR_LAST) begin
            state_d       = S_DONE;
            timeout_err_d = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gap_q         <= '0;
      gray_q        <= '0;
      gray_valid_q  <= 1'b0;
      in_row_q      <= '0;
      in_col_q      <= '0;
      pos_row_q     <= '0;
      pos_col_q     <= '0;
      out_cnt_q     <= '0;
      flush_cnt_q   <= '0;
      drain_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      gray_q        <= gray_d;
      gray_valid_q  <= gray_valid_d;
      in_row_q      <= in_row_d;
      in_col_q      <= in_col_d;
      pos_row_q     <= pos_row_d;
      pos_col_q     <= pos_col_d;
      out_cnt_q     <= out_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_bilat_frame_ctrl.sv
// tb_bilat_frame_ctrl: directed bench for bilat_frame_ctrl.
// Small 8x6 frame; table vectors plus whole-frame sequences.
module tb_bilat_frame_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int GP = 1;
  localparam int FP = 18;
  localparam int DT = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        gray_valid;
  logic [7:0]  gray;
  logic        bilat_valid;
  logic [31:0] in_row;
  logic [31:0] in_col;
  logic [31:0] out_cnt;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bilat_frame_ctrl #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .GAP          (GP),
    .FLUSH_PIXELS (FP),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .gray_valid (gray_valid),
    .gray       (gray),
    .bilat_valid(bilat_valid),
    .in_row     (in_row),
    .in_col     (in_col),
    .out_cnt    (out_cnt),
    .busy       (busy),
    .frame_done (frame_done),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic        start;
    logic        abort;
    logic        sv;
    logic [7:0]  data;
    logic        bil;
    logic        e_rdy;
    logic        e_gv;
    logic [7:0]  e_gray;
    logic        e_busy;
    logic        e_done;
    logic [31:0] e_col;
    logic [31:0] e_out;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // pixel offered during cycle t; pixel k is taken at t=2k
  function automatic logic [7:0] pix(input int t);
    int v;
    v = (t / 2) * 5 + 1;
    return v[7:0];
  endfunction

  // One frame with s_valid held high. Expected timing for
  // 8x6, GAP=1, 18 flush pixels: accepts at even t<96,
  // gray_valid at odd t<=131, DRAIN from t=131.
  // stop_at>=0 ends the run early at that cycle's negedge.
  task automatic run_frame(input string tag,
                           input int b0s, input int b0n,
                           input int b1s, input int b1n,
                           input int exp_done,
                           input int exp_out,
                           input int exp_to,
                           input int stop_at);
    int last;
    int e_rdy, e_gv, e_dat, e_dn, e_bz;
    int f_rdy, f_gv, f_dat, f_dn, f_bz;
    logic x_rdy, x_gv;
    logic [7:0] x_gray;
    e_rdy = 0; e_gv = 0; e_dat = 0; e_dn = 0; e_bz = 0;
    f_rdy = -1; f_gv = -1; f_dat = -1; f_dn = -1; f_bz = -1;
    last = (stop_at >= 0) ? stop_at : exp_done + 1;
    start = 1'b1;
    abort = 1'b0;
    s_valid = 1'b1;
    s_data = pix(0);
    bilat_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t <= last; t++) begin
      bilat_valid = (t >= b0s && t < b0s + b0n) ||
                    (t >= b1s && t < b1s + b1n);
      s_data = pix(t);
      @(negedge clk);
      if (t == 0) begin
        chk({tag, "_row0"}, in_row, 32'd0);
        chk({tag, "_col0"}, in_col, 32'd0);
        chk({tag, "_out0"}, out_cnt, 32'd0);
        chk({tag, "_to0"}, {31'd0, timeout_err}, 32'd0);
      end
      x_rdy = (t < 96) && (t % 2 == 0);
      x_gv = (t % 2 == 1) && (t <= 131);
      x_gray = (t <= 95) ? pix(t - 1) : 8'h00;
      if (s_ready !== x_rdy) begin
        e_rdy++;
        if (f_rdy < 0) f_rdy = t;
      end
      if (gray_valid !== x_gv) begin
        e_gv++;
        if (f_gv < 0) f_gv = t;
      end
      if (x_gv && gray !== x_gray) begin
        e_dat++;
        if (f_dat < 0) f_dat = t;
      end
      if (frame_done !== (t == exp_done)) begin
        e_dn++;
        if (f_dn < 0) f_dn = t;
      end
      if (busy !== (t <= exp_done)) begin
        e_bz++;
        if (f_bz < 0) f_bz = t;
      end
      if (t == 96) begin
        chk({tag, "_row_end"}, in_row, 32'd5);
        chk({tag, "_col_end"}, in_col, 32'd7);
      end
      if (stop_at < 0 && t == exp_done) begin
        chk({tag, "_out_done"}, out_cnt, 32'(exp_out));
        chk({tag, "_row_hold"}, in_row, 32'd5);
        chk({tag, "_col_hold"}, in_col, 32'd7);
      end
      if (t == last) break;
      @(posedge clk); #1;
    end
    chk($sformatf("%s_ready t=%0d", tag, f_rdy), 32'(e_rdy), 0);
    chk($sformatf("%s_gvalid t=%0d", tag, f_gv), 32'(e_gv), 0);
    chk($sformatf("%s_gray t=%0d", tag, f_dat), 32'(e_dat), 0);
    chk($sformatf("%s_done t=%0d", tag, f_dn), 32'(e_dn), 0);
    chk($sformatf("%s_busy t=%0d", tag, f_bz), 32'(e_bz), 0);
    if (stop_at < 0) begin
      chk({tag, "_to"}, {31'd0, timeout_err}, 32'(exp_to));
      chk({tag, "_out_hold"}, out_cnt, 32'(exp_out));
      @(posedge clk); #1;
      s_valid = 1'b0;
      bilat_valid = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    bilat_valid = 1'b0;

    // start, abort, sv, data, bil |
    // rdy, gv, gray, busy, done, in_col, out_cnt
    vecs[0]  = '{0,0,0,8'h00,0, 0,0,8'h00,0,0, 0,0};
    vecs[1]  = '{1,0,0,8'h00,0, 0,0,8'h00,0,0, 0,0};
    vecs[2]  = '{0,0,1,8'h11,0, 1,0,8'h00,1,0, 0,0};
    vecs[3]  = '{0,0,1,8'h22,0, 0,1,8'h11,1,0, 0,0};
    vecs[4]  = '{0,0,1,8'h33,0, 1,0,8'h00,1,0, 0,0};
    vecs[5]  = '{0,0,0,8'h44,0, 0,1,8'h33,1,0, 1,0};
    vecs[6]  = '{0,0,0,8'h00,0, 1,0,8'h00,1,0, 1,0};
    vecs[7]  = '{1,0,0,8'h00,0, 1,0,8'h00,1,0, 1,0};
    vecs[8]  = '{0,0,1,8'h55,0, 1,0,8'h00,1,0, 1,0};
    vecs[9]  = '{0,0,0,8'h00,1, 0,1,8'h55,1,0, 2,0};
    vecs[10] = '{0,1,0,8'h00,0, 1,0,8'h00,1,0, 2,1};
    vecs[11] = '{0,0,0,8'h00,0, 0,0,8'h00,0,0, 2,1};
    vecs[12] = '{0,0,0,8'h00,1, 0,0,8'h00,0,0, 2,1};
    vecs[13] = '{0,0,0,8'h00,0, 0,0,8'h00,0,0, 2,1};
    vecs[14] = '{1,0,0,8'h00,0, 0,0,8'h00,0,0, 2,1};
    vecs[15] = '{0,0,0,8'h00,0, 1,0,8'h00,1,0, 0,0};
    vecs[16] = '{0,1,0,8'h00,0, 1,0,8'h00,1,0, 0,0};
    vecs[17] = '{0,0,0,8'h00,0, 0,0,8'h00,0,0, 0,0};

    #2;
    chk("rst_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_gvalid", {31'd0, gray_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_out", out_cnt, 32'd0);
    chk("rst_to", {31'd0, timeout_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      start = vecs[i].start;
      abort = vecs[i].abort;
      s_valid = vecs[i].sv;
      s_data = vecs[i].data;
      bilat_valid = vecs[i].bil;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {31'd0, s_ready},
          {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_gvalid", i), {31'd0, gray_valid},
          {31'd0, vecs[i].e_gv});
      if (vecs[i].e_gv)
        chk($sformatf("v%0d_gray", i), {24'd0, gray},
            {24'd0, vecs[i].e_gray});
      chk($sformatf("v%0d_busy", i), {31'd0, busy},
          {31'd0, vecs[i].e_busy});
      chk($sformatf("v%0d_done", i), {31'd0, frame_done},
          {31'd0, vecs[i].e_done});
      chk($sformatf("v%0d_col", i), in_col, vecs[i].e_col);
      chk($sformatf("v%0d_out", i), out_cnt, vecs[i].e_out);
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    s_valid = 1'b0;
    bilat_valid = 1'b0;

    // all 48 outputs returned in DRAIN
    run_frame("ok", 100, 48, 0, 0, 149, 48, 0, -1);
    // 40 outputs only: 100-cycle drain then timeout
    run_frame("tmo", 100, 40, 0, 0, 231, 40, 1, -1);
    // target reached during FLUSH, extra pulses saturate
    run_frame("early", 50, 50, 0, 0, 132, 48, 0, -1);
    // last output lands on the final drain cycle
    run_frame("tie", 100, 40, 222, 8, 231, 48, 0, -1);

    // abort after 20 pixels
    run_frame("ab", 10, 5, 0, 0, 999, 0, 0, 40);
    chk("ab_out_pre", out_cnt, 32'd5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    s_valid = 1'b0;
    bilat_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("ab%0d_busy", k), {31'd0, busy}, 32'd0);
      chk($sformatf("ab%0d_ready", k), {31'd0, s_ready}, 32'd0);
      chk($sformatf("ab%0d_gv", k), {31'd0, gray_valid}, 32'd0);
      chk($sformatf("ab%0d_done", k), {31'd0, frame_done}, 32'd0);
      @(posedge clk); #1;
    end
    run_frame("restart", 100, 48, 0, 0, 149, 48, 0, -1);

    // async reset in the middle of FLUSH
    run_frame("rstf", 100, 5, 0, 0, 999, 0, 0, 111);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, s_ready}, 32'd0);
    chk("arst_gvalid", {31'd0, gray_valid}, 32'd0);
    chk("arst_gray", {24'd0, gray}, 32'd0);
    chk("arst_row", in_row, 32'd0);
    chk("arst_col", in_col, 32'd0);
    chk("arst_out", out_cnt, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, frame_done}, 32'd0);
    chk("arst_to", {31'd0, timeout_err}, 32'd0);
    s_valid = 1'b0;
    bilat_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd1);
    chk("post_rst_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bilat_frame_ctrl.md
BILAT_FRAME_CTRL -- requirements
Module: bilat_frame_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 320, pixels per row.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 464, rows per frame.
REQ-003 SHALL have parameter GAP, default 1, minimum idle cycles between consecutive gray_valid pulses.
REQ-004 SHALL have parameter FLUSH_PIXELS, default 2*IMAGE_WIDTH+2, zero pixels injected after the last input pixel.
REQ-005 SHALL have parameter DRAIN_TIMEOUT, default 300000, maximum cycles spent in DRAIN.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle frame start request.
REQ-009 abort  input  1  cancels the current frame.
REQ-010 s_valid  input  1  upstream pixel valid.
REQ-011 s_ready  output  1  controller accepts pixel this cycle.
REQ-012 s_data  input  8  upstream gray pixel.
REQ-013 gray_valid  output  1  pixel strobe to the filter, registered.
REQ-014 gray  output  8  pixel to the filter, registered.
REQ-015 bilat_valid  input  1  filter output strobe.
REQ-016 in_row, in_col  output  32 each  coordinate of the last pixel sent.
REQ-017 out_cnt  output  32  filter outputs counted this frame.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 frame_done  output  1  one-cycle completion pulse.
REQ-020 timeout_err  output  1  sticky drain-timeout flag.

Function
REQ-021 SHALL implement states IDLE, STREAM, FLUSH, DRAIN and DONE.
REQ-022 IDLE: s_ready=0, gray_valid=0; start moves to STREAM and clears in_row, in_col, out_cnt, the gap counter and timeout_err.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 STREAM: s_ready=1 only when the gap counter is 0; the gap counter loads GAP on every gray_valid pulse and decrements to 0.
REQ-025 Accept (s_valid&&s_ready) SHALL register gray=s_data and gray_valid=1 on the next edge (latency 1 cycle); gray_valid otherwise 0.
REQ-026 in_col SHALL increment per accepted pixel and wrap from IMAGE_WIDTH-1 to 0 with in_row+1.
REQ-027 Accepting pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1) SHALL move to FLUSH; s_ready=0 from the following cycle.
REQ-028 FLUSH: emit exactly FLUSH_PIXELS pulses with gray=0 under the same GAP pacing, then move to DRAIN; in_row/in_col hold.
REQ-029 DRAIN: move to DONE when out_cnt==IMAGE_WIDTH*IMAGE_HEIGHT, or when the drain counter reaches DRAIN_TIMEOUT, which also sets timeout_err.
REQ-030 out_cnt SHALL increment on bilat_valid in STREAM, FLUSH and DRAIN, saturate at IMAGE_WIDTH*IMAGE_HEIGHT, and ignore bilat_valid in IDLE/DONE.
REQ-031 DONE: frame_done=1 for exactly one cycle, then IDLE; out_cnt and timeout_err hold until the next start.
REQ-032 abort (any non-IDLE state) SHALL force IDLE on the next edge, gray_valid=0, no frame_done; abort has priority over every other transition.
REQ-033 If out_cnt reaches the target while still in FLUSH, FLUSH SHALL still complete; DRAIN then exits after 1 cycle.
REQ-034 Simultaneous timeout and count-complete in DRAIN SHALL count as success (timeout_err=0).

Reset
REQ-035 rst SHALL asynchronously force IDLE, all outputs 0, and all counters 0, including mid-frame.
REQ-036 The first start is honored on the first edge after rst deasserts.

Verification (W=8, H=6, GAP=1, FLUSH_PIXELS=18, DRAIN_TIMEOUT=100)
REQ-037 start, s_valid held 1 -> s_ready alternates 1/0; 48 gray_valid pulses carrying s_data; in_row/in_col reach 5/7; then 18 zero pulses.
REQ-038 Bench model returns 48 bilat_valid during FLUSH/DRAIN -> out_cnt=48, frame_done one pulse, timeout_err=0, busy falls with DONE exit.
REQ-039 Only 40 bilat_valid returned -> DRAIN lasts 100 cycles, timeout_err=1, frame_done pulses, out_cnt=40.
REQ-040 abort after 20 pixels -> IDLE next cycle, no frame_done, s_ready=0; a new start restarts at in_row=0, in_col=0, out_cnt=0.
REQ-041 rst asserted mid-FLUSH -> all outputs 0 immediately (no clock edge needed); start mid-STREAM and bilat_valid in IDLE -> no effect.
